alu_instr_sequencer: RTL and testbench
======================================

// Module: alu_instr_sequencer
// PURPOSE
//  Moore control FSM that sequences the CPU datapath through fetch (T0-T2) and execute (T3-T6).
//  Supports the three-register ALU class, MUL/DIV (HI/LO write-back), NOP and HALT.
//  Drives every datapath strobe (PCout, MARin, MDRin, Yin, ZLowIn, ...).
//  Sub-module sel_encode decodes IR register fields into per-register Rin/Rout one-hots.
// PARAMETERS
//  OPW           5   opcode / alu_op width (IR[31:27])
//  NREGS         16  general registers; width of Rin_bus/Rout_bus
//  MEM_WAIT_MAX  15  max cycles held in T1 awaiting mem_ready before HALT with mem_err
// PORTS
//  Clock      in   1      system clock; all state changes on rising edge
//  Clear      in   1      synchronous reset, active-low
//  ir         in   32     IR register contents; valid from T3; Ra=[26:23] Rb=[22:19] Rc=[18:15]
//  mem_ready  in   1      memory data on Mdatain valid this cycle
//  Stop       in   1      request halt at next instruction boundary
//  PCout, ZHighout, Zlowout, MDRout                      out 1  bus drive enables
//  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn out 1  register load enables
//  IncPC, Read                                           out 1  PC increment, memory read
//  alu_op     out  OPW    ALU function; equals ir[31:27] in T4, else 0
//  Rin_bus    out  NREGS  one-hot register load (from sel_encode)
//  Rout_bus   out  NREGS  one-hot register bus drive (from sel_encode)
//  Run        out  1      1 in all states except RESET and HALT
//  illegal    out  1      sticky: undefined opcode decoded
//  mem_err    out  1      sticky: MEM_WAIT_MAX exceeded
// BEHAVIOUR
//  States: RESET, T0, T1, T2, T3, T4, T5, T6, HALT. All outputs are pure functions of state
//  and ir; none are asserted in RESET/HALT.
//  Clear==0 at any edge -> RESET next cycle: every output 0, wait counter 0, sticky flags 0.
//  RESET -> T0 on first edge with Clear==1.
//  T0: PCout, MARin, IncPC, PCin. -> T1.
//  T1: Read, MDRin. Stay while mem_ready==0; leave on edge sampling mem_ready==1 -> T2.
//      Wait counter counts cycles in T1 with mem_ready==0; reaching MEM_WAIT_MAX -> HALT,
//      mem_err=1. Counter clears on T1 exit.
//  T2: MDRout, IRin. Branch on ir[31:27] (IR loaded this edge; decode uses next-cycle ir):
//      T2 -> T3 always; class resolved in T3 (ALU3/MULDIV), NOP/HALT/illegal exit T3 without strobes.
//  Opcodes (package): ADD 00011, SUB 00100, OR 00101, AND 00110, SHR 00111, SHL 01000,
//      ROR 01001, ROL 01010, MUL 01111, DIV 10000, NOP 11010, HALT 11011; others illegal.
//  T3: ALU3/MULDIV: Grb, Rout, Yin -> T4. NOP -> T0. HALT -> HALT. illegal: set illegal -> T0.
//  T4: Grc, Rout, alu_op=opcode, ZLowIn; MULDIV also ZHighIn. -> T5.
//  T5: ALU3: Zlowout, Gra, Rin -> T0. MULDIV: Zlowout, LOin -> T6.
//  T6: ZHighout, HIin -> T0.
//  Stop sampled on every transition into T0; if 1, go HALT instead (instruction completes).
//  HALT exits only via Clear. Clear has priority over every transition.
//  Never assert Rin and Rout together; never assert two bus drivers in one cycle.
//  Latency: ALU3 = 6 cycles, MULDIV = 7, NOP = 4 (mem_ready immediate).
// STRUCTURE
//  Package cpu_ctrl_pkg: opcode constants, state encoding, field bit positions.
//  Sub-module sel_encode: (ir, Gra, Grb, Grc, Rin, Rout) -> Rin_bus, Rout_bus;
//  4-to-16 decode of selected field, gated by Rin/Rout.
//  Top: state register, wait counter, sticky flags, output decode.
// TESTING
//  Reset: Clear=0 two edges -> all outputs 0, Run=0; Clear=1 -> T0 with PCout=MARin=IncPC=PCin=1.
//  OR R1,R2,R3: ir=0x28918000, mem_ready=1 -> T3 Rout_bus=0x0004+Yin; T4 Rout_bus=0x0008,
//      alu_op=00101, ZLowIn; T5 Rin_bus=0x0002+Zlowout; then T0 (6 cycles total).
//  Mem wait: mem_ready=0 for 3 cycles in T1 -> Read=MDRin=1 for 4 cycles, then T2, mem_err=0.
//  MUL R4,R5: opcode 01111 -> T4 ZLowIn+ZHighIn; T5 LOin+Zlowout; T6 HIin+ZHighout;
//      Rin_bus 0 throughout.
//  HALT/timeout: opcode 11011 -> Run=0 after T3 and held; mem_ready=0 for 15 cycles -> HALT, mem_err=1.
//  Clear=0 mid-T4 -> next edge all outputs 0, RESET; Stop=1 during T5 -> HALT, not T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the ALU instruction sequencer:
// opcode constants, FSM state encoding, instruction classes and IR field positions.
package cpu_ctrl_pkg;

   localparam int OPW              = 5;
   localparam int NREGS            = 16;
   localparam int REGW             = 4;
   localparam int MEM_WAIT_MAX_DEF = 15;

   localparam int OP_LSB = 27;
   localparam int RA_LSB = 23;
   localparam int RB_LSB = 19;
   localparam int RC_LSB = 15;

   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_OR   = 5'b00101;
   localparam logic [OPW-1:0] OP_AND  = 5'b00110;
   localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
   localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
   localparam logic [OPW-1:0] OP_ROR  = 5'b01001;
   localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
   localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPW-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      C_ALU3, C_MULDIV, C_NOP, C_HALT, C_ILLEGAL
   } iclass_t;

   function automatic iclass_t op_class(input logic [OPW-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_OR, OP_AND,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: return C_ALU3;
         OP_MUL, OP_DIV:                 return C_MULDIV;
         OP_NOP:                         return C_NOP;
         OP_HALT:                        return C_HALT;
         default:                        return C_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control bus between the sequencer (slave side here) and the datapath (master side):
// instruction/memory status into the FSM, strobes and register one-hots out of it.
interface alu_instr_sequencer_if;
   import cpu_ctrl_pkg::*;

   logic [31:0]      ir;
   logic             mem_ready;
   logic             Stop;

   logic             PCout, ZHighout, Zlowout, MDRout;
   logic             MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
   logic             IncPC, Read;
   logic [OPW-1:0]   alu_op;
   logic [NREGS-1:0] Rin_bus, Rout_bus;
   logic             Run, illegal, mem_err;

   modport master (
      output ir, mem_ready, Stop,
      input  PCout, ZHighout, Zlowout, MDRout,
      input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
      input  IncPC, Read, alu_op, Rin_bus, Rout_bus, Run, illegal, mem_err
   );

   modport slave (
      input  ir, mem_ready, Stop,
      output PCout, ZHighout, Zlowout, MDRout,
      output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
      output IncPC, Read, alu_op, Rin_bus, Rout_bus, Run, illegal, mem_err
   );

endinterface

// File: rtl/sel_encode.sv
// Register select: picks the Ra/Rb/Rc field of IR and expands it to one-hot
// load (Rin_bus) and drive (Rout_bus) vectors gated by Rin/Rout.
module sel_encode
   import cpu_ctrl_pkg::*;
(
   input  logic [RA_LSB+REGW-1:RC_LSB] ir,
   input  logic                        Gra,
   input  logic                        Grb,
   input  logic                        Grc,
   input  logic                        Rin,
   input  logic                        Rout,
   output logic [NREGS-1:0]            Rin_bus,
   output logic [NREGS-1:0]            Rout_bus
);

   logic [REGW-1:0] w_field;

   always_comb begin
      w_field = '0;
      if (Gra)
         w_field = ir[RA_LSB +: REGW];
      else if (Grb)
         w_field = ir[RB_LSB +: REGW];
      else if (Grc)
         w_field = ir[RC_LSB +: REGW];
   end

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_dec
         assign Rin_bus[gi]  = Rin  && (w_field == REGW'(gi));
         assign Rout_bus[gi] = Rout && (w_field == REGW'(gi));
      end
   endgenerate

endmodule

// File: rtl/alu_instr_sequencer.sv
// Moore control FSM stepping the datapath through fetch (T0-T2) and execute (T3-T6)
// for ALU3, MUL/DIV, NOP and HALT, with memory-wait timeout and sticky error flags.
module alu_instr_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
)
(
   input  logic                 Clock,
   input  logic                 Clear,
   alu_instr_sequencer_if.slave bus
);

   localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

   state_t            r_state;
   logic [WAIT_W-1:0] r_wait;
   logic              r_illegal;
   logic              r_mem_err;

   logic [OPW-1:0] w_op;
   iclass_t        w_class;
   logic           w_exec;
   state_t         w_boundary;
   logic           w_unused_ir;

   assign w_op        = bus.ir[OP_LSB +: OPW];
   assign w_class     = op_class(w_op);
   assign w_exec      = (w_class == C_ALU3) || (w_class == C_MULDIV);
   assign w_boundary  = bus.Stop ? S_HALT : S_T0;
   assign w_unused_ir = ^bus.ir[RC_LSB-1:0];

   always_ff @(posedge Clock) begin
      if (!Clear) begin
         r_state   <= S_RESET;
         r_wait    <= '0;
         r_illegal <= 1'b0;
         r_mem_err <= 1'b0;
      end else begin
         case (r_state)
            S_RESET: r_state <= w_boundary;
            S_T0:    r_state <= S_T1;
            S_T1: begin
               if (bus.mem_ready) begin
                  r_state <= S_T2;
                  r_wait  <= '0;
               end else if (r_wait == WAIT_W'(MEM_WAIT_MAX - 1)) begin
                  r_state   <= S_HALT;
                  r_wait    <= '0;
                  r_mem_err <= 1'b1;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_T2:    r_state <= S_T3;
            // IR was loaded on the T2 edge, so the class is only known here.
            S_T3: begin
               case (w_class)
                  C_ALU3, C_MULDIV: r_state <= S_T4;
                  C_NOP:            r_state <= w_boundary;
                  C_HALT:           r_state <= S_HALT;
                  default: begin
                     r_illegal <= 1'b1;
                     r_state   <= w_boundary;
                  end
               endcase
            end
            S_T4:    r_state <= S_T5;
            S_T5:    r_state <= (w_class == C_MULDIV) ? S_T6 : w_boundary;
            S_T6:    r_state <= w_boundary;
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_RESET;
         endcase
      end
   end

   logic w_pcout, w_zhighout, w_zlowout, w_mdrout;
   logic w_marin, w_pcin, w_mdrin, w_irin, w_yin, w_hiin, w_loin, w_zhighin, w_zlowin;
   logic w_incpc, w_read;
   logic w_gra, w_grb, w_grc, w_rin, w_rout;

   always_comb begin
      w_pcout = 1'b0; w_zhighout = 1'b0; w_zlowout = 1'b0; w_mdrout = 1'b0;
      w_marin = 1'b0; w_pcin = 1'b0; w_mdrin = 1'b0; w_irin = 1'b0;
      w_yin = 1'b0; w_hiin = 1'b0; w_loin = 1'b0; w_zhighin = 1'b0; w_zlowin = 1'b0;
      w_incpc = 1'b0; w_read = 1'b0;
      w_gra = 1'b0; w_grb = 1'b0; w_grc = 1'b0; w_rin = 1'b0; w_rout = 1'b0;
      case (r_state)
         S_T0: begin
            w_pcout = 1'b1; w_marin = 1'b1; w_incpc = 1'b1; w_pcin = 1'b1;
         end
         S_T1: begin
            w_read = 1'b1; w_mdrin = 1'b1;
         end
         S_T2: begin
            w_mdrout = 1'b1; w_irin = 1'b1;
         end
         S_T3: begin
            if (w_exec) begin
               w_grb = 1'b1; w_rout = 1'b1; w_yin = 1'b1;
            end
         end
         S_T4: begin
            w_grc     = 1'b1; w_rout = 1'b1; w_zlowin = 1'b1;
            w_zhighin = (w_class == C_MULDIV);
         end
         S_T5: begin
            w_zlowout = 1'b1;
            if (w_class == C_MULDIV) begin
               w_loin = 1'b1;
            end else begin
               w_gra = 1'b1; w_rin = 1'b1;
            end
         end
         S_T6: begin
            w_zhighout = 1'b1; w_hiin = 1'b1;
         end
         default: ;
      endcase
   end

   sel_encode u_sel (
      .ir       (bus.ir[RA_LSB+REGW-1:RC_LSB]),
      .Gra      (w_gra),
      .Grb      (w_grb),
      .Grc      (w_grc),
      .Rin      (w_rin),
      .Rout     (w_rout),
      .Rin_bus  (bus.Rin_bus),
      .Rout_bus (bus.Rout_bus)
   );

   assign bus.PCout    = w_pcout;
   assign bus.ZHighout = w_zhighout;
   assign bus.Zlowout  = w_zlowout;
   assign bus.MDRout   = w_mdrout;
   assign bus.MARin    = w_marin;
   assign bus.PCin     = w_pcin;
   assign bus.MDRin    = w_mdrin;
   assign bus.IRin     = w_irin;
   assign bus.Yin      = w_yin;
   assign bus.HIin     = w_hiin;
   assign bus.LOin     = w_loin;
   assign bus.ZHighIn  = w_zhighin;
   assign bus.ZLowIn   = w_zlowin;
   assign bus.IncPC    = w_incpc;
   assign bus.Read     = w_read;
   assign bus.alu_op   = (r_state == S_T4) ? w_op : '0;
   assign bus.Run      = (r_state != S_RESET) && (r_state != S_HALT);
   assign bus.illegal  = r_illegal;
   assign bus.mem_err  = r_mem_err;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle
// micro-operation list (fetch, then class-specific execute) and compared cycle by cycle.
module tb_alu_instr_sequencer;

   localparam int WAIT_LIMIT = 15;

   localparam logic [15:0] F_PCOUT    = 16'h8000;
   localparam logic [15:0] F_ZHIGHOUT = 16'h4000;
   localparam logic [15:0] F_ZLOWOUT  = 16'h2000;
   localparam logic [15:0] F_MDROUT   = 16'h1000;
   localparam logic [15:0] F_MARIN    = 16'h0800;
   localparam logic [15:0] F_PCIN     = 16'h0400;
   localparam logic [15:0] F_MDRIN    = 16'h0200;
   localparam logic [15:0] F_IRIN     = 16'h0100;
   localparam logic [15:0] F_YIN      = 16'h0080;
   localparam logic [15:0] F_HIIN     = 16'h0040;
   localparam logic [15:0] F_LOIN     = 16'h0020;
   localparam logic [15:0] F_ZHIGHIN  = 16'h0010;
   localparam logic [15:0] F_ZLOWIN   = 16'h0008;
   localparam logic [15:0] F_INCPC    = 16'h0004;
   localparam logic [15:0] F_READ     = 16'h0002;
   localparam logic [15:0] F_RUN      = 16'h0001;

   localparam int K_ALU3 = 0, K_MULDIV = 1, K_NOP = 2, K_HALT = 3, K_ILL = 4;

   logic Clock = 1'b0;
   logic Clear;
   alu_instr_sequencer_if bus();

   alu_instr_sequencer #(.MEM_WAIT_MAX(WAIT_LIMIT)) dut (
      .Clock (Clock),
      .Clear (Clear),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic m_ill    = 1'b0;
   logic m_merr   = 1'b0;

   logic [4:0] legal_ops [12] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                  5'b01001, 5'b01010, 5'b01111, 5'b10000, 5'b11010, 5'b11011};

   function automatic int classify(input logic [4:0] op);
      if (op >= 5'b00011 && op <= 5'b01010) return K_ALU3;
      if (op == 5'b01111 || op == 5'b10000) return K_MULDIV;
      if (op == 5'b11010) return K_NOP;
      if (op == 5'b11011) return K_HALT;
      return K_ILL;
   endfunction

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'h0};
   endfunction

   function automatic logic [54:0] ev(input logic [15:0] f, input logic [4:0] a,
                                      input logic [15:0] rin, input logic [15:0] rout);
      return {f, a, rin, rout, m_ill, m_merr};
   endfunction

   function automatic logic [54:0] observe();
      return {bus.PCout, bus.ZHighout, bus.Zlowout, bus.MDRout, bus.MARin, bus.PCin,
              bus.MDRin, bus.IRin, bus.Yin, bus.HIin, bus.LOin, bus.ZHighIn, bus.ZLowIn,
              bus.IncPC, bus.Read, bus.Run, bus.alu_op, bus.Rin_bus, bus.Rout_bus,
              bus.illegal, bus.mem_err};
   endfunction

   task automatic check(input string tag, input logic [54:0] exp);
      logic [54:0] obs;
      @(negedge Clock);
      #1;
      obs = observe();
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      Clear         = 1'b0;
      bus.Stop      = 1'b0;
      bus.mem_ready = 1'b0;
      m_ill         = 1'b0;
      m_merr        = 1'b0;
      check("reset_a", ev(16'h0, 5'h0, 16'h0, 16'h0));
      check("reset_b", ev(16'h0, 5'h0, 16'h0, 16'h0));
      Clear = 1'b1;
   endtask

   // One instruction from T0: the expected cycles are listed first, then played back.
   task automatic run_instr(input string name, input logic [31:0] irv, input int waits,
                            input bit stp, input int abort_at, output bit halted);
      logic [54:0] q[$];
      string       tg[$];
      logic [4:0]  op;
      logic [15:0] ra1, rb1, rc1;
      int          cls;
      int          n_t1;
      bit          timeout;
      op      = irv[31:27];
      cls     = classify(op);
      ra1     = 16'd1 << irv[26:23];
      rb1     = 16'd1 << irv[22:19];
      rc1     = 16'd1 << irv[18:15];
      timeout = (waits >= WAIT_LIMIT);
      n_t1    = timeout ? WAIT_LIMIT : waits + 1;
      halted  = 1'b0;

      q.push_back(ev(F_PCOUT | F_MARIN | F_INCPC | F_PCIN | F_RUN, 5'h0, 16'h0, 16'h0));
      tg.push_back({name, "/T0"});
      for (int k = 0; k < n_t1; k++) begin
         q.push_back(ev(F_READ | F_MDRIN | F_RUN, 5'h0, 16'h0, 16'h0));
         tg.push_back($sformatf("%s/T1.%0d", name, k));
      end
      if (timeout) begin
         m_merr = 1'b1;
         halted = 1'b1;
      end else begin
         q.push_back(ev(F_MDROUT | F_IRIN | F_RUN, 5'h0, 16'h0, 16'h0));
         tg.push_back({name, "/T2"});
         if (cls == K_ALU3 || cls == K_MULDIV) begin
            q.push_back(ev(F_YIN | F_RUN, 5'h0, 16'h0, rb1));
            tg.push_back({name, "/T3"});
            q.push_back(ev(F_ZLOWIN | F_RUN | ((cls == K_MULDIV) ? F_ZHIGHIN : 16'h0),
                           op, 16'h0, rc1));
            tg.push_back({name, "/T4"});
            if (cls == K_ALU3) begin
               q.push_back(ev(F_ZLOWOUT | F_RUN, 5'h0, ra1, 16'h0));
               tg.push_back({name, "/T5"});
            end else begin
               q.push_back(ev(F_ZLOWOUT | F_LOIN | F_RUN, 5'h0, 16'h0, 16'h0));
               tg.push_back({name, "/T5"});
               q.push_back(ev(F_ZHIGHOUT | F_HIIN | F_RUN, 5'h0, 16'h0, 16'h0));
               tg.push_back({name, "/T6"});
            end
         end else begin
            q.push_back(ev(F_RUN, 5'h0, 16'h0, 16'h0));
            tg.push_back({name, "/T3"});
            if (cls == K_HALT) halted = 1'b1;
            if (cls == K_ILL)  m_ill  = 1'b1;
         end
         if (stp) halted = 1'b1;
      end
      if (halted) begin
         for (int k = 0; k < 3; k++) begin
            q.push_back(ev(16'h0, 5'h0, 16'h0, 16'h0));
            tg.push_back($sformatf("%s/HALT.%0d", name, k));
         end
      end

      for (int i = 0; i < q.size(); i++) begin
         check(tg[i], q[i]);
         if (i == abort_at) return;
         bus.Stop = stp;
         if (i >= 1 && i <= n_t1)
            bus.mem_ready = (i == n_t1) && !timeout;
         else
            bus.mem_ready = 1'($urandom_range(0, 1));
         if (i == n_t1 + 1 && !timeout)
            bus.ir = irv;
      end
      $display("instr %s ir=%h waits=%0d stop=%0b class=%0d halted=%0b",
               name, irv, waits, stp, cls, halted);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          h;
      logic [31:0] r_ir;
      int          waits;
      bit          stp;

      Clear         = 1'b0;
      bus.ir        = 32'h0;
      bus.mem_ready = 1'b0;
      bus.Stop      = 1'b0;

      do_reset();
      run_instr("or_r1_r2_r3", 32'h2891_8000, 0, 1'b0, -1, h);
      run_instr("add_wait3", mk_ir(5'b00011, 4'd7, 4'd8, 4'd9), 3, 1'b0, -1, h);
      run_instr("mul_r4_r5", mk_ir(5'b01111, 4'd0, 4'd4, 4'd5), 0, 1'b0, -1, h);
      run_instr("div", mk_ir(5'b10000, 4'd3, 4'd15, 4'd0), 1, 1'b0, -1, h);
      run_instr("nop", mk_ir(5'b11010, 4'd1, 4'd2, 4'd3), 0, 1'b0, -1, h);
      run_instr("illegal", mk_ir(5'b00000, 4'd1, 4'd2, 4'd3), 0, 1'b0, -1, h);
      run_instr("rol_after_ill", mk_ir(5'b01010, 4'd15, 4'd0, 4'd14), 2, 1'b0, -1, h);
      run_instr("halt_op", mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, 1'b0, -1, h);
      do_reset();
      run_instr("wait14", mk_ir(5'b00110, 4'd2, 4'd6, 4'd10), 14, 1'b0, -1, h);
      run_instr("timeout", mk_ir(5'b00100, 4'd1, 4'd1, 4'd1), WAIT_LIMIT, 1'b0, -1, h);
      do_reset();
      run_instr("clear_mid_t4", mk_ir(5'b00100, 4'd5, 4'd6, 4'd7), 0, 1'b0, 4, h);
      do_reset();
      run_instr("stop_alu", 32'h2891_8000, 0, 1'b1, -1, h);
      do_reset();
      run_instr("stop_muldiv", mk_ir(5'b01111, 4'd9, 4'd11, 4'd12), 1, 1'b1, -1, h);
      do_reset();

      for (int n = 0; n < 40; n++) begin
         r_ir = $urandom();
         if ($urandom_range(0, 5) != 0)
            r_ir[31:27] = legal_ops[$urandom_range(0, 11)];
         waits = $urandom_range(0, 4);
         stp   = ($urandom_range(0, 9) == 0);
         run_instr($sformatf("rnd%0d", n), r_ir, waits, stp, -1, h);
         if (h) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
